mem_arbiter_fsm: RTL and testbench
==================================

// Module: mem_arbiter_fsm
// PURPOSE
//  Sequences the single shared, pipelined main memory between the I-cache miss path and the D-cache miss/write path.
//  On a miss it issues an 8-word line fill and steers the returned words to the missing cache.
//  Forwards D-side write-through stores as single-cycle memory writes.
//  Sits between the FETCH/MEMORY-stage caches and main memory; the hazard unit uses its ic_busy/dc_busy outputs as stall sources.
// PARAMETERS
//  ADDR_W   16  byte-address width
//  DATA_W   16  word width
//  LINE_WDS 8   words per cache line (line = 16 bytes; power of 2)
//  MEM_LAT  4   cycles from a read issue (mem_en & !mem_wr) to the matching mem_valid
// PORTS
//  clk          in  1       clock
//  rst_n        in  1       synchronous active-low reset
//  ic_miss      in  1       I-cache miss request; level, held until ic_fill_done
//  ic_addr      in  ADDR_W  I-side miss address (any byte in line)
//  dc_miss      in  1       D-cache miss request; level, held until dc_fill_done
//  dc_addr      in  ADDR_W  D-side miss address
//  dc_wr        in  1       D-side write-through request; level, held until dc_wr_ack
//  dc_wr_addr   in  ADDR_W  store address
//  dc_wr_data   in  DATA_W  store data
//  mem_en       out 1       memory access enable
//  mem_wr       out 1       1=write, 0=read
//  mem_addr     out ADDR_W  memory byte address
//  mem_wdata    out DATA_W  memory write data
//  mem_rdata    in  DATA_W  memory read data, qualified by mem_valid
//  mem_valid    in  1       read data valid
//  fill_data    out DATA_W  returned word (mem_rdata registered through)
//  fill_idx     out log2(LINE_WDS)  word index of fill_data within the line
//  ic_fill_we   out 1       write fill_data into the I-cache line
//  dc_fill_we   out 1       write fill_data into the D-cache line
//  ic_fill_done out 1       1-cycle pulse: I-side line complete
//  dc_fill_done out 1       1-cycle pulse: D-side line complete
//  dc_wr_ack    out 1       1-cycle pulse: store issued to memory
//  ic_busy      out 1       ic_miss pending or being serviced
//  dc_busy      out 1       dc_miss or dc_wr pending or being serviced
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; counters=0. Reset mid-fill aborts the fill; no done pulse.
//    Memory shares rst_n, so no stale mem_valid arrives after reset.
//    Any mem_valid seen outside FILL/DRAIN is ignored.
//  - States:
//    - IDLE: grant in priority order dc_wr > dc_miss > ic_miss; evaluated only in IDLE.
//    - WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data; dc_wr_ack=1. Next state IDLE.
//    - FILL: latch owner (I/D) and base = addr & ~(2*LINE_WDS-1). Issue one read per cycle for
//      LINE_WDS cycles, mem_addr = base | {issue_cnt,1'b0}. Then go to DRAIN.
//    - DRAIN: wait until ret_cnt reaches LINE_WDS. Then go to DONE.
//    - DONE (1 cycle): owner's *_fill_done=1. Next state IDLE.
//  - Return path (FILL or DRAIN): each mem_valid registers fill_data=mem_rdata, fill_idx=ret_cnt, and the owner's *_fill_we=1,
//    all one cycle after mem_valid. Then ret_cnt++.
//    Words return in issue order. ret_cnt may advance while issuing (MEM_LAT < LINE_WDS).
//  - Latency: miss grant to *_fill_done = 1 + (LINE_WDS-1) + MEM_LAT + 2 cycles (=14 at defaults);
//    store = 1 cycle after grant.
//  - Counters are log2(LINE_WDS)+1 bits; no wrap within a line. An extra mem_valid beyond LINE_WDS is ignored.
//  - Back-to-back: after DONE/WRITE the FSM always passes through IDLE (1 bubble) before the next grant.
//  - ic_busy/dc_busy are combinational from the request levels plus the current owner.
//  - A request dropped before grant is never serviced.
//  - A request dropped mid-service is still completed, and its done pulse is still issued.
// CONFIGURATION
//  ARB_RR_EN defined:
//    - When both ic_miss and dc_miss are pending in IDLE, round-robin applies: the side not served last wins.
//    - A last_owner flop resets to I, so D wins the first tie.
//    - dc_wr keeps absolute priority.
//  ARB_RR_EN undefined: fixed priority dc_wr > dc_miss > ic_miss; no last_owner flop.
// TESTING
//  T1 I-miss:
//    - Stimulus: ic_miss=1, ic_addr=0x0046; memory returns word = address.
//    - Required: mem_addr 0x0040..0x004E over 8 consecutive cycles.
//    - Required: ic_fill_we x8 with fill_idx 0..7 and fill_data 0x0040..0x004E.
//    - Required: ic_fill_done pulse 14 cycles after the grant; no dc_* activity.
//  T2 store:
//    - Stimulus: dc_wr=1, dc_wr_addr=0x1002, dc_wr_data=0xBEEF.
//    - Required: one cycle of mem_en=1, mem_wr=1 with matching address and data; dc_wr_ack pulse; FSM back in IDLE next cycle.
//  T3 simultaneous requests:
//    - Stimulus: dc_wr, dc_miss (0x2000) and ic_miss (0x0010) all asserted in the same cycle.
//    - Required: service order WRITE -> D fill -> I fill, with one IDLE bubble between each.
//    - Required with ARB_RR_EN: a repeated D/I tie alternates the winner.
//  T4 reset mid-fill:
//    - Stimulus: assert rst_n=0 after 3 words have returned.
//    - Required: all outputs 0 next cycle; no *_fill_done; a new ic_miss after reset refetches all 8 words from fill_idx 0.
//  T5 stray mem_valid:
//    - Stimulus: pulse mem_valid while IDLE.
//    - Required: no *_fill_we; ret_cnt stays 0.
//  T6 late request drop:
//    - Stimulus: deassert dc_miss during DRAIN.
//    - Required: the fill completes; dc_fill_done still pulses; dc_busy=0 after DONE.

Source files
------------

// File: rtl/mem_arbiter_fsm.sv
// Shared-memory sequencer: arbitrates I/D line fills and D-side write-through stores.
// Optional round-robin arbitration of I/D miss ties when ARB_RR_EN is defined.
module mem_arbiter_fsm #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LINE_WDS = 8,
  parameter int MEM_LAT  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_ic_miss,
  input  logic [ADDR_W-1:0]           i_ic_addr,
  input  logic                        i_dc_miss,
  input  logic [ADDR_W-1:0]           i_dc_addr,
  input  logic                        i_dc_wr,
  input  logic [ADDR_W-1:0]           i_dc_wr_addr,
  input  logic [DATA_W-1:0]           i_dc_wr_data,
  output logic                        o_mem_en,
  output logic                        o_mem_wr,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  input  logic                        i_mem_valid,
  output logic [DATA_W-1:0]           o_fill_data,
  output logic [$clog2(LINE_WDS)-1:0] o_fill_idx,
  output logic                        o_ic_fill_we,
  output logic                        o_dc_fill_we,
  output logic                        o_ic_fill_done,
  output logic                        o_dc_fill_done,
  output logic                        o_dc_wr_ack,
  output logic                        o_ic_busy,
  output logic                        o_dc_busy
);

  localparam int IDX_W = $clog2(LINE_WDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(2 * LINE_WDS - 1);

  // Reject configurations the counters and address masking cannot represent.
  if (MEM_LAT < 1 || LINE_WDS < 2 || (LINE_WDS & (LINE_WDS - 1)) != 0) begin : g_badCfg
    $error("mem_arbiter_fsm: LINE_WDS must be a power of 2 >= 2 and MEM_LAT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_ownerD;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_issueCnt, r_retCnt;
  logic [DATA_W-1:0]   r_fillData;
  logic [IDX_W-1:0]    r_fillIdx;
  logic                r_icFillWe, r_dcFillWe;
  logic                w_tieD, w_grantD, w_fillGrant, w_ret, w_svcI, w_svcD;

  assign w_fillGrant = (r_state == S_IDLE) && !i_dc_wr && (i_dc_miss || i_ic_miss);
  assign w_grantD    = i_dc_miss && (!i_ic_miss || w_tieD);

`ifdef ARB_RR_EN
  // Remembers the side served by the previous fill so an I/D tie goes to the other one.
  logic r_lastD;
  always_ff @(posedge clk) begin
    if (!rst_n)           r_lastD <= 1'b0;
    else if (w_fillGrant) r_lastD <= w_grantD;
  end
  assign w_tieD = !r_lastD;
`else
  assign w_tieD = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ownerD   <= 1'b0;
      r_base     <= '0;
      r_issueCnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_issueCnt <= '0;
      else if (r_state == S_FILL) r_issueCnt <= r_issueCnt + CNT_W'(1);
      if (w_fillGrant) begin
        r_ownerD <= w_grantD;
        r_base   <= (w_grantD ? i_dc_addr : i_ic_addr) & ~LINE_MASK;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    o_mem_en       = 1'b0;
    o_mem_wr       = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_dc_wr_ack    = 1'b0;
    o_ic_fill_done = 1'b0;
    o_dc_fill_done = 1'b0;
    w_svcI         = 1'b0;
    w_svcD         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dc_wr)                     w_next = S_WRITE;
        else if (i_dc_miss || i_ic_miss) w_next = S_FILL;
      end
      S_WRITE: begin
        o_mem_en    = 1'b1;
        o_mem_wr    = 1'b1;
        o_mem_addr  = i_dc_wr_addr;
        o_mem_wdata = i_dc_wr_data;
        o_dc_wr_ack = 1'b1;
        w_svcD      = 1'b1;
        w_next      = S_IDLE;
      end
      S_FILL: begin
        o_mem_en   = 1'b1;
        o_mem_addr = r_base | ADDR_W'({r_issueCnt[IDX_W-1:0], 1'b0});
        w_svcI     = !r_ownerD;
        w_svcD     = r_ownerD;
        if (r_issueCnt == CNT_W'(LINE_WDS - 1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_svcI = !r_ownerD;
        w_svcD = r_ownerD;
        if (r_retCnt == CNT_W'(LINE_WDS)) w_next = S_DONE;
      end
      S_DONE: begin
        o_ic_fill_done = !r_ownerD;
        o_dc_fill_done = r_ownerD;
        w_svcI         = !r_ownerD;
        w_svcD         = r_ownerD;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Returned words are only accepted while a fill is outstanding and the line is not yet full.
  assign w_ret = (r_state == S_FILL || r_state == S_DRAIN) && i_mem_valid &&
                 (r_retCnt < CNT_W'(LINE_WDS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retCnt   <= '0;
      r_fillData <= '0;
      r_fillIdx  <= '0;
      r_icFillWe <= 1'b0;
      r_dcFillWe <= 1'b0;
    end else begin
      r_icFillWe <= w_ret && !r_ownerD;
      r_dcFillWe <= w_ret && r_ownerD;
      if (w_ret) begin
        r_fillData <= i_mem_rdata;
        r_fillIdx  <= r_retCnt[IDX_W-1:0];
        r_retCnt   <= r_retCnt + CNT_W'(1);
      end else if (r_state == S_IDLE) begin
        r_retCnt <= '0;
      end
    end
  end

  assign o_fill_data  = r_fillData;
  assign o_fill_idx   = r_fillIdx;
  assign o_ic_fill_we = r_icFillWe;
  assign o_dc_fill_we = r_dcFillWe;
  assign o_ic_busy    = i_ic_miss || w_svcI;
  assign o_dc_busy    = i_dc_miss || i_dc_wr || w_svcD;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Bench for mem_arbiter_fsm: timeline model of grants/fills checked every cycle, plus directed literal checks.
// Build with ARB_RR_EN defined to exercise round-robin tie handling.
module tb_mem_arbiter_fsm;

  localparam int N   = 2048;
  localparam int LW  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic icMiss = 0, dcMiss = 0, dcWr = 0;
  logic [15:0] icAddr = '0, dcAddr = '0, dcWrAddr = '0, dcWrData = '0;
  logic memValid = 0;
  logic [15:0] memRdata = '0;
  logic memEn, memWr, icFillWe, dcFillWe, icFillDone, dcFillDone, dcWrAck, icBusy, dcBusy;
  logic [15:0] memAddr, memWdata, fillData;
  logic [2:0] fillIdx;
  logic stray = 0;
  int cyc = 0;
  int nVectors = 0, nMiscompares = 0;

  mem_arbiter_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .i_ic_miss(icMiss), .i_ic_addr(icAddr),
    .i_dc_miss(dcMiss), .i_dc_addr(dcAddr),
    .i_dc_wr(dcWr), .i_dc_wr_addr(dcWrAddr), .i_dc_wr_data(dcWrData),
    .o_mem_en(memEn), .o_mem_wr(memWr), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata), .i_mem_valid(memValid),
    .o_fill_data(fillData), .o_fill_idx(fillIdx),
    .o_ic_fill_we(icFillWe), .o_dc_fill_we(dcFillWe),
    .o_ic_fill_done(icFillDone), .o_dc_fill_done(dcFillDone),
    .o_dc_wr_ack(dcWrAck), .o_ic_busy(icBusy), .o_dc_busy(dcBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Pipelined memory: each read returns its own address LAT cycles after issue.
  logic [4:0] pV;
  logic [15:0] pA [5];
  always @(negedge clk) begin
    if (!rst_n) begin
      pV = '0;
      memValid = 1'b0;
      memRdata = '0;
    end else begin
      for (int k = 4; k > 0; k--) begin
        pV[k] = pV[k-1];
        pA[k] = pA[k-1];
      end
      pV[0] = memEn && !memWr;
      pA[0] = memAddr;
      memValid = pV[4] | stray;
      memRdata = stray ? 16'hDEAD : pA[4];
    end
  end

  // Expected-output timeline indexed by cycle, filled in whenever the model grants.
  bit sEn[N], sWr[N], sIcWe[N], sDcWe[N], sIcDone[N], sDcDone[N], sAck[N], sSvcI[N], sSvcD[N];
  logic [15:0] sAddr[N], sWdata[N], sData[N];
  logic [2:0] sIdx[N];
  bit modelOn = 0, lastD = 0;
  int freeAt = 0;

  task automatic planGrant(input int c);
    bit pickD;
    logic [15:0] base;
    if (c + 16 >= N) begin
      checkOutput("model_range", 32'(c), 32'(N - 16));
    end else if (dcWr) begin
      sEn[c+1] = 1; sWr[c+1] = 1; sAddr[c+1] = dcWrAddr; sWdata[c+1] = dcWrData;
      sAck[c+1] = 1; sSvcD[c+1] = 1;
      freeAt = c + 2;
    end else if (dcMiss || icMiss) begin
`ifdef ARB_RR_EN
      pickD = (dcMiss && icMiss) ? !lastD : dcMiss;
`else
      pickD = dcMiss;
`endif
      base = (pickD ? dcAddr : icAddr) & 16'hFFF0;
      for (int k = 0; k < LW; k++) begin
        sEn[c+1+k] = 1;
        sAddr[c+1+k] = base + 16'(2 * k);
        if (pickD) sDcWe[c+LAT+2+k] = 1; else sIcWe[c+LAT+2+k] = 1;
        sData[c+LAT+2+k] = base + 16'(2 * k);
        sIdx[c+LAT+2+k] = 3'(k);
      end
      for (int k = 1; k <= LW + LAT + 2; k++) begin
        if (pickD) sSvcD[c+k] = 1; else sSvcI[c+k] = 1;
      end
      if (pickD) sDcDone[c+LW+LAT+2] = 1; else sIcDone[c+LW+LAT+2] = 1;
      freeAt = c + LW + LAT + 3;
      lastD = pickD;
    end
  endtask

  task automatic checkCycle(input int c);
    checkOutput("mem_en", 32'(memEn), 32'(sEn[c]));
    checkOutput("mem_wr", 32'(memWr), 32'(sWr[c]));
    if (sEn[c]) checkOutput("mem_addr", 32'(memAddr), 32'(sAddr[c]));
    if (sWr[c]) checkOutput("mem_wdata", 32'(memWdata), 32'(sWdata[c]));
    checkOutput("ic_fill_we", 32'(icFillWe), 32'(sIcWe[c]));
    checkOutput("dc_fill_we", 32'(dcFillWe), 32'(sDcWe[c]));
    if (sIcWe[c] || sDcWe[c]) begin
      checkOutput("fill_data", 32'(fillData), 32'(sData[c]));
      checkOutput("fill_idx", 32'(fillIdx), 32'(sIdx[c]));
    end
    checkOutput("ic_fill_done", 32'(icFillDone), 32'(sIcDone[c]));
    checkOutput("dc_fill_done", 32'(dcFillDone), 32'(sDcDone[c]));
    checkOutput("dc_wr_ack", 32'(dcWrAck), 32'(sAck[c]));
    checkOutput("ic_busy", 32'(icBusy), 32'(icMiss | sSvcI[c]));
    checkOutput("dc_busy", 32'(dcBusy), 32'(dcMiss | dcWr | sSvcD[c]));
  endtask

  always @(negedge clk) begin
    if (modelOn) checkCycle(cyc);
    if (!rst_n) begin
      modelOn = 1;
      for (int c = cyc + 1; c < N; c++) begin
        sEn[c] = 0; sWr[c] = 0; sIcWe[c] = 0; sDcWe[c] = 0; sIcDone[c] = 0;
        sDcDone[c] = 0; sAck[c] = 0; sSvcI[c] = 0; sSvcD[c] = 0;
      end
      freeAt = cyc + 1;
      lastD = 0;
    end else if (modelOn && cyc >= freeAt) begin
      planGrant(cyc);
    end
  end

  // Observation log for the directed literal checks.
  logic [15:0] obsRdAddr[$], obsWrAddr[$], obsWrData[$], obsIcData[$], obsDcData[$];
  int obsIcIdx[$], obsDcIdx[$], evKind[$], evCyc[$];
  always @(negedge clk) begin
    if (memEn && !memWr) obsRdAddr.push_back(memAddr);
    if (memEn && memWr) begin obsWrAddr.push_back(memAddr); obsWrData.push_back(memWdata); end
    if (icFillWe) begin obsIcData.push_back(fillData); obsIcIdx.push_back(int'(fillIdx)); end
    if (dcFillWe) begin obsDcData.push_back(fillData); obsDcIdx.push_back(int'(fillIdx)); end
    if (dcWrAck)    begin evKind.push_back(0); evCyc.push_back(cyc); end
    if (dcFillDone) begin evKind.push_back(1); evCyc.push_back(cyc); end
    if (icFillDone) begin evKind.push_back(2); evCyc.push_back(cyc); end
  end

  task automatic clearObs();
    obsRdAddr.delete(); obsWrAddr.delete(); obsWrData.delete(); obsIcData.delete();
    obsDcData.delete(); obsIcIdx.delete(); obsDcIdx.delete(); evKind.delete(); evCyc.delete();
  endtask

  task automatic stepCycle(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic icM, input logic [15:0] icA, input logic dcM,
                               input logic [15:0] dcA, input logic dW, input logic [15:0] wA,
                               input logic [15:0] wD);
    icMiss = icM; icAddr = icA; dcMiss = dcM; dcAddr = dcA;
    dcWr = dW; dcWrAddr = wA; dcWrData = wD;
  endtask

  // Behaves like the caches: each request drops the cycle after its done/ack pulse.
  task automatic runUntilIdle(input string name, input int maxCyc);
    logic dI, dD, dW;
    int n = 0;
    while ((icMiss || dcMiss || dcWr) && n < maxCyc) begin
      @(negedge clk);
      dI = icFillDone; dD = dcFillDone; dW = dcWrAck;
      @(posedge clk); #1;
      if (dI) icMiss = 0;
      if (dD) dcMiss = 0;
      if (dW) dcWr = 0;
      n++;
    end
    if (icMiss || dcMiss || dcWr) begin
      checkOutput({name, "_timeout"}, 32'(n), 32'(maxCyc + 1));
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic finishRun();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  endtask

  initial begin
    #100000;
    checkOutput("watchdog", 32'(0), 32'(1));
    finishRun();
  end

  logic [15:0] t1Addr [8];
  int startCyc, n, nDone;
  int tieExp [3];

  initial begin
    t1Addr = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048, 16'h004A, 16'h004C, 16'h004E};
    rst_n = 0;
    stepCycle(3);
    rst_n = 1;
    stepCycle(1);
    $display("[TB] reset state");
    checkOutput("rst_mem_en", 32'(memEn), 0);
    checkOutput("rst_fill_data", 32'(fillData), 0);
    checkOutput("rst_busy", 32'({icBusy, dcBusy}), 0);

    $display("[TB] T1 I-miss");
    clearObs();
    startCyc = cyc;
    applyStimulus(1, 16'h0046, 0, 0, 0, 0, 0);
    runUntilIdle("T1", 40);
    stepCycle(2);
    checkOutput("T1_nreads", 32'(obsRdAddr.size()), 8);
    checkOutput("T1_nwe", 32'(obsIcIdx.size()), 8);
    checkOutput("T1_dc_we", 32'(obsDcIdx.size()), 0);
    for (int k = 0; k < 8; k++) begin
      if (k < obsRdAddr.size()) checkOutput("T1_addr", 32'(obsRdAddr[k]), 32'(t1Addr[k]));
      if (k < obsIcIdx.size()) begin
        checkOutput("T1_idx", 32'(obsIcIdx[k]), 32'(k));
        checkOutput("T1_data", 32'(obsIcData[k]), 32'(t1Addr[k]));
      end
    end
    checkOutput("T1_nev", 32'(evKind.size()), 1);
    if (evKind.size() == 1) begin
      checkOutput("T1_kind", 32'(evKind[0]), 2);
      checkOutput("T1_latency", 32'(evCyc[0] - startCyc), 14);
    end

    $display("[TB] T2 store");
    clearObs();
    startCyc = cyc;
    applyStimulus(0, 0, 0, 0, 1, 16'h1002, 16'hBEEF);
    runUntilIdle("T2", 10);
    stepCycle(2);
    checkOutput("T2_nwr", 32'(obsWrAddr.size()), 1);
    if (obsWrAddr.size() == 1) begin
      checkOutput("T2_addr", 32'(obsWrAddr[0]), 32'h1002);
      checkOutput("T2_data", 32'(obsWrData[0]), 32'hBEEF);
    end
    checkOutput("T2_nev", 32'(evKind.size()), 1);
    if (evKind.size() == 1) checkOutput("T2_ack_cyc", 32'(evCyc[0] - startCyc), 1);

    $display("[TB] T3 simultaneous requests");
    clearObs();
    applyStimulus(1, 16'h0010, 1, 16'h2000, 1, 16'h2222, 16'h1234);
    runUntilIdle("T3", 80);
    stepCycle(2);
    checkOutput("T3_nev", 32'(evKind.size()), 3);
    if (evKind.size() == 3) begin
      checkOutput("T3_order", 32'({evKind[0], evKind[1], evKind[2]}), 32'({0, 1, 2}));
      checkOutput("T3_gap_wd", 32'(evCyc[1] - evCyc[0]), 15);
      checkOutput("T3_gap_di", 32'(evCyc[2] - evCyc[1]), 15);
    end
    if (obsRdAddr.size() == 16) begin
      checkOutput("T3_d_base", 32'(obsRdAddr[0]), 32'h2000);
      checkOutput("T3_i_base", 32'(obsRdAddr[8]), 32'h0010);
    end else checkOutput("T3_nreads", 32'(obsRdAddr.size()), 16);

    $display("[TB] T3b repeated I/D tie");
    clearObs();
`ifdef ARB_RR_EN
    tieExp = '{1, 2, 1};
`else
    tieExp = '{1, 1, 1};
`endif
    applyStimulus(1, 16'h5020, 1, 16'h4000, 0, 0, 0);
    n = 0; nDone = 0;
    while (nDone < 3 && n < 80) begin
      @(negedge clk);
      if (icFillDone || dcFillDone) nDone++;
      stepCycle(1);
      n++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stepCycle(2);
    checkOutput("T3b_ndone", 32'(evKind.size()), 3);
    for (int k = 0; k < 3; k++)
      if (k < evKind.size()) checkOutput("T3b_winner", 32'(evKind[k]), 32'(tieExp[k]));

    $display("[TB] T4 reset mid-fill");
    clearObs();
    applyStimulus(1, 16'h0104, 0, 0, 0, 0, 0);
    n = 0;
    while (obsIcIdx.size() < 3 && n < 40) begin stepCycle(1); n++; end
    checkOutput("T4_three_words", 32'(obsIcIdx.size()), 3);
    rst_n = 0;
    icMiss = 0;
    stepCycle(1);
    rst_n = 1;
    checkOutput("T4_rst_outs", 32'({memEn, memWr, icFillWe, dcFillWe, icFillDone, dcWrAck, icBusy}), 0);
    checkOutput("T4_rst_fill", 32'({fillData, 13'(fillIdx)}), 0);
    stepCycle(3);
    checkOutput("T4_no_done", 32'(evKind.size()), 0);
    clearObs();
    applyStimulus(1, 16'h0104, 0, 0, 0, 0, 0);
    runUntilIdle("T4", 40);
    stepCycle(2);
    checkOutput("T4_refetch_n", 32'(obsIcIdx.size()), 8);
    for (int k = 0; k < 8; k++)
      if (k < obsIcIdx.size()) begin
        checkOutput("T4_idx", 32'(obsIcIdx[k]), 32'(k));
        checkOutput("T4_data", 32'(obsIcData[k]), 32'(16'h0100 + 16'(2 * k)));
      end

    $display("[TB] T5 stray mem_valid");
    clearObs();
    stray = 1;
    stepCycle(1);
    stray = 0;
    stepCycle(3);
    checkOutput("T5_no_we", 32'(obsIcIdx.size() + obsDcIdx.size()), 0);
    applyStimulus(0, 0, 1, 16'h6006, 0, 0, 0);
    runUntilIdle("T5", 40);
    stepCycle(2);
    checkOutput("T5_dc_n", 32'(obsDcIdx.size()), 8);
    if (obsDcIdx.size() > 0) begin
      checkOutput("T5_first_idx", 32'(obsDcIdx[0]), 0);
      checkOutput("T5_first_data", 32'(obsDcData[0]), 32'h6000);
    end

    $display("[TB] T6 drop during drain");
    clearObs();
    applyStimulus(0, 0, 1, 16'h3008, 0, 0, 0);
    n = 0;
    stepCycle(1);
    while (memEn && n < 20) begin stepCycle(1); n++; end
    checkOutput("T6_reach_drain", 32'(n), 8);
    dcMiss = 0;
    n = 0;
    @(negedge clk);
    while (!dcFillDone && n < 20) begin @(negedge clk); n++; end
    checkOutput("T6_done", 32'(dcFillDone), 1);
    stepCycle(1);
    checkOutput("T6_busy_after", 32'(dcBusy), 0);
    checkOutput("T6_words", 32'(obsDcIdx.size()), 8);
    stepCycle(3);

    finishRun();
  end

endmodule
